// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared FSM state encoding and default width for serial_adder.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fa_bit.sv
`default_nettype none
// ============================================================================
//  Module   : fa_bit
//  Purpose  : One-bit full adder built from two half-adder cells and an OR.
//  Revision : 1.0 - initial release
// ============================================================================
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha1 (
        .a (a),
        .b (b),
        .s (w_s1),
        .c (w_c1)
    );

    half_adder u_ha2 (
        .a (w_s1),
        .b (cin),
        .s (s),
        .c (w_c2)
    );

    assign cout = w_c1 | w_c2;

endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module   : half_adder
//  Purpose  : Combinational half-adder cell (sum = a^b, carry = a&b).
//  Revision : 1.0 - initial release
// ============================================================================
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : LSB-first bit-serial adder with start/done handshake.
//             Define SERIAL_ADDER_SUB_EN to add a 'sub' input (a - b).
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             car
);

    localparam int              c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cw-1:0]    r_cnt;
    logic               r_carry;
    logic               r_car;
    logic               w_accept;
    logic               w_last;
    logic               w_sub;
    logic               w_fa_s;
    logic               w_fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // start is only honoured when no add is in flight
    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == c_last);

    fa_bit u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_car   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + c_cw'(1);
            if (w_last) begin
                r_car <= w_fa_c;
            end
        end
    end

    assign sum = r_sum;
    assign car = r_car;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock.
- The per-bit add is a full-add built from two of the team's existing half-adder cells plus a carry flip-flop.
- Sits directly downstream of the half-adder cell and consumes its sum/carry outputs.
- Gives the lab a sequential stage (FSM, shift registers, counter, start/done handshake) on top of the combinational cell.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result; holds its value until the next accepted start
- car  output  1  carry-out of the MSB; holds with sum

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, sum=0, car=0.
  - Operand shift registers, carry flop and bit counter are cleared.
  - Takes effect immediately, including mid-SHIFT; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - Latch a and b into shift registers; carry flop=0; counter=0.
  - Next state SHIFT.
- SHIFT, each edge:
  - fa = LSB(A) + LSB(B) + carry, formed as HA1(A0,B0) followed by HA2(s1,carry); cout = c1 OR c2.
  - sum shifts right with fa's sum bit entering at the MSB; carry flop=cout.
  - A and B shift right; counter increments.
  - Bits are processed at edges k+1 .. k+WIDTH.
  - At the edge where counter==WIDTH-1: next state DONE and car=cout.
- DONE: entered after edge k+WIDTH.
  - done=1 for exactly that cycle; sum/car are valid.
  - Next edge: start=1 → accepted as in IDLE (back-to-back, no dead cycle); start=0 → IDLE.
- Latency: start sampled at edge k → done=1 and result valid after edge k+WIDTH.
- Throughput: one add every WIDTH+1 cycles.
- start during SHIFT is ignored; a and b may change freely after acceptance.
- busy=1 exactly in SHIFT; busy and done are never both high.
- sum/car hold through IDLE; during SHIFT sum contains partial shifted data and is not valid.
- Arithmetic is unsigned modulo 2^WIDTH; car is bit WIDTH of a+b.
- Counter width is $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port `sub` (1 bit), sampled with start.
  - sub=1 latches ~b and initialises the carry flop to 1, so sum = a-b mod 2^WIDTH.
  - car=1 means no borrow (a≥b).
  - sub=0 behaves exactly as the base add.
- Undefined: no `sub` port; add only; the carry flop always initialises to 0.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant.
- Sub-module fa_bit: one full-add cell from two instances of the existing half-adder cell plus an OR.
- Top: FSM, operand/result shift registers, counter and carry flop.

Test Plan:
- Zero add: a=8'h00, b=8'h00, start → done after 8 cycles; sum=8'h00, car=0; busy high for exactly 8 cycles.
- Carry chain: a=8'hFF, b=8'h01 → sum=8'h00, car=1.
- Mixed add: a=8'h5A, b=8'h3C → sum=8'h96, car=0. Pulse start again mid-SHIFT with a=8'h01: it must be ignored and the result unchanged.
- Back-to-back: start held high in the DONE cycle with a=8'h80, b=8'h80 → next done 9 cycles after the first; sum=8'h00, car=1.
- Reset mid-op: rst_n low at cycle 4 of SHIFT → busy, done, sum and car go 0 immediately; after release the FSM is in IDLE and the next add (8'h03+8'h04) gives sum=8'h07, car=0.
- SERIAL_ADDER_SUB_EN:
  - sub=1, a=8'h10, b=8'h01 → sum=8'h0F, car=1.
  - sub=1, a=8'h01, b=8'h02 → sum=8'hFF, car=0.
